// File: rtl/mag_comp_serial.sv
// mag_comp_serial: bit-serial magnitude comparator.
// Latches two WIDTH-bit operands on start and scans them one bit per clock,
// MSB first. The scan stops at the first differing bit and reports one-hot
// eq/gt/lt with a one-cycle done pulse. Unsigned and two's-complement
// comparison are both supported. The signed case only changes the meaning of
// a difference in the sign bit.
module mag_comp_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             smode_q;
    logic [IDX_W-1:0] idx;

    // Bit pair currently under inspection, taken from the latched operands
    // so that input changes during a scan cannot disturb the result.
    logic bit_a;
    logic bit_b;
    logic bits_differ;
    logic at_sign_bit;

    assign bit_a       = a_q[idx];
    assign bit_b       = b_q[idx];
    assign bits_differ = bit_a ^ bit_b;
    // A 1 in the sign bit marks the smaller operand, so the normal rule is
    // inverted only at the MSB of a signed comparison.
    assign at_sign_bit = smode_q && (idx == MSB_IDX);

    // Control FSM, operand latches, bit index and the registered result flags.
    // NOTE: every register here uses <= so each one sees the values from before
    // this edge. A blocking = would let later statements read the new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            smode_q <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            // done is a pulse. Clearing it by default means only a finishing
            // edge raises it, and it falls again on the following edge.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        smode_q <= signed_mode;
                        idx     <= MSB_IDX;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end

                SCAN: begin
                    if (bits_differ) begin
                        eq    <= 1'b0;
                        gt    <= at_sign_bit ? bit_b : bit_a;
                        lt    <= at_sign_bit ? bit_a : bit_b;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (idx == '0) begin
                        eq    <= 1'b1;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A completed comparison always yields exactly one flag.
    a_result_onehot : assert property (
        @(posedge clk) disable iff (!rst_n) done |-> $onehot({eq, gt, lt})
    );

    // done marks the end of a scan, so busy must already be low in that cycle.
    a_done_not_busy : assert property (
        @(posedge clk) disable iff (!rst_n) done |-> !busy
    );

endmodule

// File: tb/tb_mag_comp_serial.sv
// Testbench for mag_comp_serial (WIDTH = 8).
// Expected flags and latency come from a behavioural model. They are queued
// when a start is driven, and a monitor pops them when done pulses.
module tb_mag_comp_serial;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    mag_comp_serial #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt)
    );

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   start_edge;
        int   lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    logic prev_done  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference model: plain integer comparison plus the MSB-first search
    // for the first differing bit to derive the latency in edges.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input int se);
        exp_t r;
        logic found;
        r.eq = (x == y);
        if (s) begin
            r.gt = ($signed(x) > $signed(y));
            r.lt = ($signed(x) < $signed(y));
        end else begin
            r.gt = (x > y);
            r.lt = (x < y);
        end
        r.start_edge = se;
        r.lat = WIDTH;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && (x[i] != y[i])) begin
                r.lat = WIDTH - i;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Monitor: scores every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) check("done_one_cycle", {31'b0, done}, 32'd0);
            if (done) begin
                check("busy_at_done", {31'b0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("flags", {29'b0, eq, gt, lt}, {29'b0, mon_e.eq, mon_e.gt, mon_e.lt});
                    check("latency", cyc - mon_e.start_edge, mon_e.lat);
                end
            end
        end
        prev_done = done && rst_n;
    end

    // Raise start with the given operands right now (caller is at a negedge).
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, input logic push);
        a           = x;
        b           = y;
        signed_mode = s;
        start       = 1'b1;
        if (push) sb.push_back(model(x, y, s, cyc + 1));
    endtask

    task automatic start_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        @(negedge clk);
        launch(x, y, s, 1'b1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; busy must hold high throughout the scan.
    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 4 * WIDTH) begin
            check("busy_scan", {31'b0, busy}, 32'd1);
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;

        // Reset, then idle with start low.
        repeat (2) @(negedge clk);
        check("reset_outputs", {27'b0, busy, done, eq, gt, lt}, 32'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_outputs", {27'b0, busy, done, eq, gt, lt}, 32'd0);
        end

        // Directed cases.
        start_cmp(8'hA5, 8'hA5, 1'b0); wait_done();
        start_cmp(8'h80, 8'h7F, 1'b0); wait_done();
        start_cmp(8'h80, 8'h7F, 1'b1); wait_done();
        start_cmp(8'h12, 8'h13, 1'b0); wait_done();
        start_cmp(8'hFE, 8'hFF, 1'b1); wait_done();

        // Flags hold after done.
        @(negedge clk);
        check("flags_hold", {29'b0, eq, gt, lt}, {29'b0, 1'b0, 1'b0, 1'b1});

        // Start and operand changes during a scan are ignored.
        @(negedge clk);
        launch(8'h0F, 8'h0E, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h55; b = 8'hAA; signed_mode = 1'b1;
        wait_done();
        repeat (WIDTH + 2) @(negedge clk);

        // Reset abort three cycles into a scan.
        launch(8'h01, 8'h00, 1'b0, 1'b0);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {27'b0, busy, done, eq, gt, lt}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 4) @(negedge clk);
        check("abort_no_result", {28'b0, busy, eq, gt, lt}, 32'd0);

        // Back-to-back: second start raised in the first comparison's done cycle.
        start_cmp(8'h40, 8'h20, 1'b0);
        wait_done();
        launch(8'h03, 8'h03, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_done();

        // Random operands in both modes.
        for (int k = 0; k < 24; k++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            x = WIDTH'($urandom);
            y = (k % 4 == 0) ? x ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0)) : WIDTH'($urandom);
            start_cmp(x, y, 1'(k & 1));
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
